reg_dump_uart_tx: RTL

Debug register-dump transmitter for the DE0 processor build. On a start pulse it snapshots the processor's eight 16-bit general registers (R0–R7, the same debug outputs the processor exposes to the bench) and streams them off-board as a framed 8N1 UART byte sequence. The block drives the board TX pin, so register state can be read on a host instead of in a simulator waveform.

---
 rtl/reg_dump_uart_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/reg_dump_uart_tx.sv
// Snapshots R0..R7 on start and streams an 18-byte 8N1 UART frame:
// 0xA5 header, 16 big-endian register bytes (R0 first), then an 8-bit checksum.
module reg_dump_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] R0,
  input  logic [15:0] R1,
  input  logic [15:0] R2,
  input  logic [15:0] R3,
  input  logic [15:0] R4,
  input  logic [15:0] R5,
  input  logic [15:0] R6,
  input  logic [15:0] R7,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_BYTE = 5'd17;
  localparam logic [7:0]    HEADER    = 8'hA5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [4:0]    byte_q, byte_d;
  logic [7:0]    snap_q [16];
  logic [7:0]    snap_d [16];
  logic [7:0]    csum_q, csum_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [15:0]   r_c [8];
  logic [7:0]    sum_c;
  logic [7:0]    cur_byte_c;
  logic          baud_end_c;

  assign r_c[0] = R0;
  assign r_c[1] = R1;
  assign r_c[2] = R2;
  assign r_c[3] = R3;
  assign r_c[4] = R4;
  assign r_c[5] = R5;
  assign r_c[6] = R6;
  assign r_c[7] = R7;

  // Checksum precomputed from the live inputs and captured with the snapshot
  always_comb begin
    sum_c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sum_c = sum_c + r_c[i][15:8] + r_c[i][7:0];
    end
  end

  always_comb begin
    cur_byte_c = HEADER;
    if (byte_q == LAST_BYTE) begin
      cur_byte_c = csum_q;
    end else if (byte_q != 5'd0) begin
      cur_byte_c = snap_q[4'(byte_q - 5'd1)];
    end
  end

  assign baud_end_c = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 5'd0;
      csum_q  <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) snap_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) snap_q[i] <= snap_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    csum_d  = csum_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    for (int i = 0; i < 16; i++) snap_d[i] = snap_q[i];

    if (state_q != S_IDLE) begin
      baud_d = baud_end_c ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
          csum_d  = sum_c;
          for (int i = 0; i < 8; i++) begin
            snap_d[2*i]   = r_c[i][15:8];
            snap_d[2*i+1] = r_c[i][7:0];
          end
        end
      end
      S_START: begin
        if (baud_end_c) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte_c[0];
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte_c[bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (baud_end_c) begin
          if (byte_q < LAST_BYTE) begin
            state_d = S_START;
            byte_d  = byte_q + 5'd1;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            byte_d  = 5'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
